adc_scan_sequencer: RTL

- Round-robin scheduler for a multi-channel 12-bit ADC; triggers conversions, waits on the converter's done handshake, and stores one result register per channel.
- Sits between the ADC front-end and the LED bar-graph display logic; exposes a display-select mux so one channel's latest sample drives the LEDs.
- Scans are paced by an interval counter; a watchdog catches hung conversions.

---
 rtl/adc_scan_sequencer_pkg.sv | 21 ++
 rtl/adc_scan_sequencer_if.sv | 13 +
 rtl/adc_scan_sequencer_picker.sv | 25 ++
 rtl/adc_scan_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/adc_scan_sequencer_pkg.sv
// Shared definitions for the ADC scan sequencer and the LED bar-graph display logic.
package adc_scan_sequencer_pkg;

  localparam int ADC_RES    = 12;
  localparam int LED_CNT    = 8;
  localparam int CH_CNT_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_START,
    S_CONVERT,
    S_WAIT
  } seq_state_e;

  // Counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/adc_scan_sequencer_if.sv
// Conversion handshake between the scan sequencer (master) and the ADC front-end (slave).
interface adc_scan_sequencer_if #(
  parameter int CH_W = 2,
  parameter int RES  = adc_scan_sequencer_pkg::ADC_RES
);
  logic            adc_start;
  logic [CH_W-1:0] adc_chan;
  logic            adc_done;
  logic [RES-1:0]  adc_data;

  modport master (output adc_start, output adc_chan, input adc_done, input adc_data);
  modport slave  (input adc_start, input adc_chan, output adc_done, output adc_data);
endinterface

// File: rtl/adc_scan_sequencer_picker.sv
// adc_chan_picker: lowest masked channel at or above the scan pointer (pure combinational).
module adc_chan_picker #(
  parameter int CH_CNT = 4,
  parameter int CH_W   = 2
) (
  input  logic [CH_CNT-1:0] mask_i,
  input  logic [CH_W:0]     ptr_i,
  output logic [CH_W-1:0]   idx_o,
  output logic              found_o
);
  import adc_scan_sequencer_pkg::*;

  // Walk downwards so the last hit, i.e. the lowest index, wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = CH_CNT - 1; i >= 0; i--) begin
      if (mask_i[i] && (i >= int'(ptr_i))) begin
        idx_o   = CH_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Round-robin ADC scan sequencer: paces scans, triggers conversions, keeps one result per channel.
// Build option ADC_SEQ_AVG_EN: store a 2-tap running average instead of the raw sample.
module adc_scan_sequencer #(
  parameter int CH_CNT   = adc_scan_sequencer_pkg::CH_CNT_DEF,
  parameter int CH_W     = 2,
  parameter int ADC_RES  = adc_scan_sequencer_pkg::ADC_RES,
  parameter int INTERVAL = 1000,
  parameter int TIMEOUT  = 255
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      enable,
  input  logic [CH_CNT-1:0]         ch_mask,
  adc_scan_sequencer_if.master      adc,
  input  logic [CH_W-1:0]           disp_sel,
  output logic [ADC_RES-1:0]        disp_data,
  output logic                      disp_valid,
  output logic                      scan_done,
  output logic                      timeout_err,
  input  logic                      err_clr
);
  import adc_scan_sequencer_pkg::*;

  localparam int PTR_W = CH_W + 1;
  localparam int IV_W  = clog2_min1(INTERVAL);
  localparam int TO_W  = clog2_min1(TIMEOUT + 1);
  localparam logic [IV_W-1:0] IV_RELOAD = IV_W'(INTERVAL - 1);
  localparam logic [TO_W-1:0] TO_MAX    = TO_W'(TIMEOUT);

  seq_state_e state_q, state_d;

  logic [PTR_W-1:0]                ptr_q, ptr_d;
  logic [CH_W-1:0]                 chan_q, chan_d;
  logic [IV_W-1:0]                 iv_q, iv_d;
  logic [TO_W-1:0]                 to_q, to_d, to_inc;
  logic [CH_CNT-1:0][ADC_RES-1:0]  res_q, res_d;
  logic [CH_CNT-1:0]               vld_q, vld_d;
  logic                            done_q, done_d;
  logic                            err_q, err_d;
  logic [ADC_RES-1:0]              disp_data_q, disp_data_d;
  logic                            disp_vld_q, disp_vld_d;

  logic                            pick_found;
  logic [CH_W-1:0]                 pick_idx;
  logic                            conv_ack, conv_to;
  logic [ADC_RES-1:0]              store_val;

  adc_chan_picker #(.CH_CNT(CH_CNT), .CH_W(CH_W)) u_picker (
    .mask_i  (ch_mask),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign to_inc   = (to_q == TO_MAX) ? to_q : to_q + 1'b1;
  assign conv_ack = (state_q == S_CONVERT) && adc.adc_done;
  // A done in the same cycle as the limit still counts as a good conversion.
  assign conv_to  = (state_q == S_CONVERT) && !adc.adc_done && (to_inc == TO_MAX);

`ifdef ADC_SEQ_AVG_EN
  logic [ADC_RES:0] avg_sum;
  always_comb begin
    avg_sum   = {1'b0, res_q[chan_q]} + {1'b0, adc.adc_data} + {{ADC_RES{1'b0}}, 1'b1};
    store_val = vld_q[chan_q] ? avg_sum[ADC_RES:1] : adc.adc_data;
  end
`else
  assign store_val = adc.adc_data;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (enable && |ch_mask) state_d = S_SELECT;
      S_SELECT: begin
        if (!enable)        state_d = S_IDLE;
        else if (pick_found) state_d = S_START;
        else                state_d = S_WAIT;
      end
      S_START:   state_d = S_CONVERT;
      S_CONVERT: if (conv_ack || conv_to) state_d = S_SELECT;
      S_WAIT: begin
        if (!enable)         state_d = S_IDLE;
        else if (iv_q == '0) state_d = S_SELECT;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    adc.adc_start = (state_q == S_START);
    adc.adc_chan  = chan_q;
    scan_done     = done_q;
    timeout_err   = err_q;
    disp_data     = disp_data_q;
    disp_valid    = disp_vld_q;
  end

  always_comb begin
    ptr_d  = ptr_q;
    chan_d = chan_q;
    iv_d   = iv_q;
    to_d   = to_q;
    res_d  = res_q;
    vld_d  = vld_q;
    done_d = 1'b0;
    err_d  = err_q;

    // Interval runs during the whole scan and parks at 0 on overrun until WAIT is reached.
    if (state_q != S_IDLE && iv_q != '0) iv_d = iv_q - 1'b1;

    case (state_q)
      S_IDLE: if (enable && |ch_mask) begin
        iv_d  = IV_RELOAD;
        ptr_d = '0;
      end
      S_SELECT: if (enable) begin
        if (pick_found) chan_d = pick_idx;
        else            done_d = 1'b1;
      end
      S_START:   to_d = '0;
      S_CONVERT: begin
        to_d = to_inc;
        if (conv_ack) begin
          res_d[chan_q] = store_val;
          vld_d[chan_q] = 1'b1;
        end
        if (conv_ack || conv_to) ptr_d = {1'b0, chan_q} + 1'b1;
      end
      S_WAIT: if (enable && iv_q == '0) begin
        ptr_d = '0;
        iv_d  = IV_RELOAD;
      end
      default: ;
    endcase

    if (conv_to) err_d = 1'b1;
    if (err_clr) err_d = 1'b0;

    // Mux from next-state so a fresh store is visible one cycle after adc_done.
    disp_data_d = '0;
    disp_vld_d  = 1'b0;
    if (int'(disp_sel) < CH_CNT) begin
      disp_data_d = res_d[disp_sel];
      disp_vld_d  = vld_d[disp_sel];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q       <= '0;
      chan_q      <= '0;
      iv_q        <= '0;
      to_q        <= '0;
      res_q       <= '0;
      vld_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      disp_data_q <= '0;
      disp_vld_q  <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      chan_q      <= chan_d;
      iv_q        <= iv_d;
      to_q        <= to_d;
      res_q       <= res_d;
      vld_q       <= vld_d;
      done_q      <= done_d;
      err_q       <= err_d;
      disp_data_q <= disp_data_d;
      disp_vld_q  <= disp_vld_d;
    end
  end

endmodule
